data_in_packer: RTL and testbench
=================================

Name: data_in_packer

Overview:
- Ingress counterpart of the queue-unpacking output stage: accepts a byte stream framed by i_sop/i_eop with a per-packet priority and address.
- Assembles one DATAPACK_BIT-wide datapack in the format the output stage parses, then writes it into the WRR queue FIFO.
- Sits between the upstream byte source and the queue FIFO write port; applies back-pressure while a datapack is pending.

Parameters:
- DATA_WIDTH, 8, byte-stream width; fixed at 8.
- DATAPACK_BIT, 1024, datapack width (128 bytes).
- PRIORITY_BIT, 3, priority field width.
- DATA_NUMBIT, 7, byte-count width.
- ADDR_BIT, 16, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  byte valid
- i_sop  in  1  first byte of packet (qualified by i_valid)
- i_eop  in  1  last byte of packet (qualified by i_valid)
- i_data  in  DATA_WIDTH  payload byte
- i_prior  in  PRIORITY_BIT  packet priority, sampled on sop beat
- i_addr  in  ADDR_BIT  packet address, sampled on sop beat
- o_ready  out  1  byte accept; a beat transfers when i_valid && o_ready
- fifo_full  in  1  queue FIFO full
- wr_ena  out  1  queue FIFO write strobe
- Queue_in  out  DATAPACK_BIT  assembled datapack
- data_num  out  DATA_NUMBIT  total bytes in Queue_in (2 header + payload)
- o_err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset clears all state and outputs asynchronously.
  - Outputs: o_ready=0 during reset, 1 on the first cycle after release; wr_ena=0, Queue_in=0, data_num=0, o_err=0; state=IDLE.
- Datapack format, bytes numbered 127 (bits 1023:1016) down to 0:
  - byte127 = {1'b1, 4'b0, prior}
  - byte126 = {1'b1, 3'b0, addr[3:0]}
  - Payload starts at byte125 and runs downward.
  - All bytes after the last payload byte are 0x00; the first zero byte is the terminator.
  - Maximum payload is 125 bytes, so byte0 is always 0x00.
- FSM states: IDLE, COLLECT, DROP, FLUSH.
- IDLE (o_ready=1):
  - Accepted sop beat: clear Queue_in; write both header bytes; place i_data at byte125; byte pointer = 124; data_num = 3.
  - If i_eop is also set, go to FLUSH; otherwise go to COLLECT.
  - Accepted beat without sop: discard it, pulse o_err, stay in IDLE.
- COLLECT (o_ready=1):
  - Accepted non-sop beat: write the byte at the pointer, decrement the pointer, increment data_num.
  - If i_eop is set, go to FLUSH.
- COLLECT, sop before eop: abandon the partial packet, pulse o_err, and restart assembly with this beat exactly as in IDLE.
- DROP (o_ready=1): discard beats until the eop beat, then go to IDLE. No write occurs.
- Zero payload byte (i_data==0) in IDLE/COLLECT: pulse o_err and go to DROP, or to IDLE if i_eop is set.
- Overflow (126th payload byte, i.e. the pointer would reach byte0): pulse o_err and go to DROP, or to IDLE if the beat carries eop.
- FLUSH (o_ready=0):
  - wr_ena = !fifo_full, combinational from state.
  - Queue_in and data_num are held stable.
  - Leave to IDLE on the cycle wr_ena=1.
  - While fifo_full=1, stay in FLUSH indefinitely.
- Latency: eop accepted in cycle N → wr_ena in N+1 when the FIFO is not full → o_ready=1 again in N+2.
- wr_ena is at most one cycle per packet; it is never asserted outside FLUSH.
- Reset asserted mid-packet or in FLUSH: the packet is lost and no write is issued.
- i_prior/i_addr are sampled only on the accepted sop beat.

Optional Feature:
- Macro: DATA_IN_PACKER_STAT_EN.
- Defined:
  - Adds outputs pkt_cnt[15:0] and drop_cnt[15:0], both reset to 0.
  - pkt_cnt increments on each wr_ena.
  - drop_cnt increments on each o_err pulse that discards bytes.
  - Both counters wrap from 0xFFFF to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- sop beat 0x11 (prior=5, addr=0x0003), beats 0x22, 0x33 (eop), fifo_full=0:
  - wr_ena one cycle after the eop beat; data_num=5.
  - Queue_in[1023:984] = 0x85_83_11_22_33; remainder 0.
- Single beat with sop+eop, i_data=0x7F, prior=0, addr=0:
  - Queue_in[1023:1000] = 0x80_80_7F; data_num=3.
- fifo_full=1 for 10 cycles after eop:
  - wr_ena stays 0 and o_ready stays 0 during those cycles; Queue_in is stable.
  - wr_ena pulses on the cycle fifo_full drops; o_ready returns the next cycle.
- Payload byte 0x00 mid-packet:
  - o_err pulses once; the remaining beats are accepted and discarded; no wr_ena.
  - The next good packet is written correctly.
- 126 payload bytes:
  - o_err pulses on the 126th byte; no wr_ena.
  - Exactly 125 bytes: written with data_num=127 and byte0=0x00.
- Second sop with no eop in between:
  - o_err pulses; only the second packet is written, with its own header.
  - With STAT_EN: pkt_cnt=1, drop_cnt=1.

Source files
------------

// File: rtl/data_in_packer_if.sv
// Byte-stream ingress and queue-FIFO write bundle for data_in_packer.
// master = upstream source plus FIFO side; slave = the packer.
interface data_in_packer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int DATAPACK_BIT = 1024,
    parameter int PRIORITY_BIT = 3,
    parameter int DATA_NUMBIT  = 7,
    parameter int ADDR_BIT     = 16
);
    logic                    i_valid;
    logic                    i_sop;
    logic                    i_eop;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [PRIORITY_BIT-1:0] i_prior;
    logic [ADDR_BIT-1:0]     i_addr;
    logic                    o_ready;
    logic                    fifo_full;
    logic                    wr_ena;
    logic [DATAPACK_BIT-1:0] Queue_in;
    logic [DATA_NUMBIT-1:0]  data_num;
    logic                    o_err;

    modport master (
        output i_valid, i_sop, i_eop, i_data, i_prior, i_addr, fifo_full,
        input  o_ready, wr_ena, Queue_in, data_num, o_err
    );

    modport slave (
        input  i_valid, i_sop, i_eop, i_data, i_prior, i_addr, fifo_full,
        output o_ready, wr_ena, Queue_in, data_num, o_err
    );
endinterface

// File: rtl/data_in_packer.sv
// Packs an sop/eop-framed byte stream into one header-prefixed, zero-terminated datapack
// and writes it to the WRR queue FIFO. Optional counters: define DATA_IN_PACKER_STAT_EN.
module data_in_packer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DATAPACK_BIT = 1024,
    parameter int PRIORITY_BIT = 3,
    parameter int DATA_NUMBIT  = 7,
    parameter int ADDR_BIT     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    data_in_packer_if.slave   bus
`ifdef DATA_IN_PACKER_STAT_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int IDX_W = $clog2(DATAPACK_BIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    beat_s;
    logic                    zero_s;
    logic                    start_s;
    logic                    store_s;
    logic                    err_s;
    logic                    wr_ena_s;
    logic                    ready_r;
    logic                    err_r;
    logic [DATAPACK_BIT-1:0] queue_r;
    logic [DATA_NUMBIT-1:0]  num_r;
    logic [DATA_NUMBIT-1:0]  ptr_r;
    logic [IDX_W-1:0]        bit_idx_s;
    logic                    unused_addr_s;

    assign beat_s        = bus.i_valid && ready_r;
    assign zero_s        = (bus.i_data == {DATA_WIDTH{1'b0}});
    assign bit_idx_s     = {ptr_r, 3'b000};
    assign unused_addr_s = ^bus.i_addr[ADDR_BIT-1:4];

    // Next-state and per-beat control decode
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        store_s      = 1'b0;
        err_s        = 1'b0;
        wr_ena_s     = 1'b0;
        case (state_r)
            IDLE, COLLECT: begin
                if (beat_s) begin
                    if (bus.i_sop) begin
                        // a sop in COLLECT abandons the partial packet and restarts here
                        err_s = (state_r == COLLECT) || zero_s;
                        if (zero_s) begin
                            state_next_s = bus.i_eop ? IDLE : DROP;
                        end else begin
                            start_s      = 1'b1;
                            state_next_s = bus.i_eop ? FLUSH : COLLECT;
                        end
                    end else if (state_r == IDLE) begin
                        err_s        = 1'b1;
                        state_next_s = IDLE;
                    end else if (zero_s || (ptr_r == '0)) begin
                        // ptr at byte0 means the terminator slot would be overwritten
                        err_s        = 1'b1;
                        state_next_s = bus.i_eop ? IDLE : DROP;
                    end else begin
                        store_s      = 1'b1;
                        state_next_s = bus.i_eop ? FLUSH : COLLECT;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            DROP: begin
                if (beat_s && bus.i_eop) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DROP;
                end
            end
            FLUSH: begin
                wr_ena_s = !bus.fifo_full;
                if (!bus.fifo_full) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register, ready and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s != FLUSH);
            err_r   <= err_s;
        end
    end

    // Datapack assembly: header on sop, payload written downward from byte125
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_r <= '0;
            num_r   <= '0;
            ptr_r   <= '0;
        end else if (start_s) begin
            queue_r                       <= '0;
            queue_r[DATAPACK_BIT-1 -: 8]  <= {1'b1, {(7-PRIORITY_BIT){1'b0}}, bus.i_prior};
            queue_r[DATAPACK_BIT-9 -: 8]  <= {1'b1, 3'b000, bus.i_addr[3:0]};
            queue_r[DATAPACK_BIT-17 -: 8] <= bus.i_data;
            ptr_r                         <= DATA_NUMBIT'(124);
            num_r                         <= DATA_NUMBIT'(3);
        end else if (store_s) begin
            queue_r[bit_idx_s +: 8] <= bus.i_data;
            ptr_r                   <= ptr_r - DATA_NUMBIT'(1);
            num_r                   <= num_r + DATA_NUMBIT'(1);
        end else begin
            queue_r <= queue_r;
            ptr_r   <= ptr_r;
            num_r   <= num_r;
        end
    end

    assign bus.o_ready  = ready_r;
    assign bus.o_err    = err_r;
    assign bus.wr_ena   = wr_ena_s;
    assign bus.Queue_in = queue_r;
    assign bus.data_num = num_r;

`ifdef DATA_IN_PACKER_STAT_EN
    logic [15:0] pkt_cnt_r;
    logic [15:0] drop_cnt_r;

    // Written-packet and discarded-packet counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r  <= 16'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            pkt_cnt_r  <= wr_ena_s ? (pkt_cnt_r + 16'd1) : pkt_cnt_r;
            drop_cnt_r <= err_r ? (drop_cnt_r + 16'd1) : drop_cnt_r;
        end
    end

    assign pkt_cnt  = pkt_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_data_in_packer.sv
// Randomized scoreboard bench for data_in_packer with a packet-level reference model.
module tb_data_in_packer;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [1023:0] q;
        logic [6:0]    n;
    } exp_t;

    logic clk;
    logic rst_n;
    data_in_packer_if bus ();
`ifdef DATA_IN_PACKER_STAT_EN
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    data_in_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DATA_IN_PACKER_STAT_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   exp_err   = 0;
    int   err_seen  = 0;
    int   n_pushed  = 0;
    int   full_mode = 0;
    bit   gaps_en   = 1'b0;
    bit   mon_en    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int w;
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            w = 0;
            for (int i = 0; i < 16; i++)
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            $display("FAIL %s: word%0d got %h expected %h", name, w, act[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    // Reference: header bytes, payload from byte125 downward, zeros after
    function automatic logic [1023:0] model_pack(input logic [2:0] pr, input logic [15:0] ad,
                                                 input byte_q_t b);
        logic [1023:0] r;
        r = '0;
        r[1023:1016] = {5'b10000, pr};
        r[1015:1008] = {4'b1000, ad[3:0]};
        for (int i = 0; i < b.size(); i++) r[1007 - 8*i -: 8] = b[i];
        return r;
    endfunction

    // Outcome of a complete packet started from idle
    task automatic expect_pkt(input logic [2:0] pr, input logic [15:0] ad, input byte_q_t b);
        exp_t e;
        bit   bad;
        bad = (b.size() > 125);
        foreach (b[i]) if (b[i] == 8'h00) bad = 1'b1;
        if (bad) begin
            exp_err++;
        end else begin
            e.q = model_pack(pr, ad, b);
            e.n = 7'(b.size() + 2);
            sb.push_back(e);
            n_pushed++;
        end
    endtask

    // FIFO-full generator: 0 = never full, 1 = random, 2 = always full
    initial begin
        bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            case (full_mode)
                0:       bus.fifo_full = 1'b0;
                1:       bus.fifo_full = ($urandom_range(0, 2) == 0);
                default: bus.fifo_full = 1'b1;
            endcase
        end
    end

    // Monitor: pop and compare on every write strobe, count error pulses
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && mon_en) begin
                if (bus.wr_ena) begin
                    chk("wr_has_pending_pkt", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk_wide("queue_in", bus.Queue_in, e.q);
                        chk("data_num", 64'(bus.data_num), 64'(e.n));
                    end
                end
                if (bus.o_err) err_seen++;
            end
        end
    end

    // One beat, held until accepted; called at a negedge, returns at a negedge
    task automatic beat(input bit sop, input bit eop, input logic [7:0] d,
                        input logic [2:0] pr, input logic [15:0] ad);
        bit acc;
        acc = 1'b0;
        if (gaps_en && ($urandom_range(0, 3) == 0)) begin
            bus.i_valid = 1'b0;
            @(negedge clk);
        end
        bus.i_valid = 1'b1;
        bus.i_sop   = sop;
        bus.i_eop   = eop;
        bus.i_data  = d;
        bus.i_prior = pr;
        bus.i_addr  = ad;
        for (int t = 0; t < 500 && !acc; t++) begin
            #1;
            acc = bus.o_ready;
            @(negedge clk);
        end
        if (!acc) chk("beat_accept_timeout", 64'(acc), 64'd1);
        bus.i_valid = 1'b0;
        bus.i_sop   = 1'b0;
        bus.i_eop   = 1'b0;
    endtask

    task automatic send_pkt(input logic [2:0] pr, input logic [15:0] ad, input byte_q_t b,
                            input bit with_eop);
        for (int i = 0; i < b.size(); i++)
            if (i == 0) beat(1'b1, with_eop && (b.size() == 1), b[i], pr, ad);
            else beat(1'b0, with_eop && (i == b.size() - 1), b[i],
                      3'($urandom), 16'($urandom));
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(1, 255)));
        return b;
    endfunction

    task automatic run_pkt(input logic [2:0] pr, input logic [15:0] ad, input byte_q_t b);
        expect_pkt(pr, ad, b);
        send_pkt(pr, ad, b, 1'b1);
    endtask

    task automatic drain;
        full_mode = 0;
        for (int t = 0; t < 2000 && sb.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        byte_q_t       b;
        logic [1023:0] qe;
        logic [2:0]    pr;
        logic [15:0]   ad;
        int            kind;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_sop   = 1'b0;
        bus.i_eop   = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_prior = 3'd0;
        bus.i_addr  = 16'h0000;

        // reset values
        repeat (2) @(negedge clk);
        #2;
        chk("rst_o_ready", 64'(bus.o_ready), 64'd0);
        chk("rst_wr_ena", 64'(bus.wr_ena), 64'd0);
        chk_wide("rst_queue_in", bus.Queue_in, '0);
        chk("rst_data_num", 64'(bus.data_num), 64'd0);
        chk("rst_o_err", 64'(bus.o_err), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #2;
        chk("o_ready_after_reset", 64'(bus.o_ready), 64'd1);
        @(negedge clk);

        // basic three-byte packet and single sop+eop beat
        b = '{8'h11, 8'h22, 8'h33};
        run_pkt(3'd5, 16'h0003, b);
        b = '{8'h7F};
        run_pkt(3'd0, 16'h0000, b);
        drain();

        // FIFO full for 10 cycles after eop
        full_mode = 2;
        b = '{8'h11, 8'h22, 8'h33};
        qe = model_pack(3'd5, 16'h0003, b);
        run_pkt(3'd5, 16'h0003, b);
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("full_wr_ena", 64'(bus.wr_ena), 64'd0);
            chk("full_o_ready", 64'(bus.o_ready), 64'd0);
            chk_wide("full_queue_stable", bus.Queue_in, qe);
            @(negedge clk);
        end
        full_mode = 0;
        @(negedge clk);
        #2;
        chk("release_wr_ena", 64'(bus.wr_ena), 64'd1);
        chk("release_o_ready", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        #2;
        chk("ready_after_write", 64'(bus.o_ready), 64'd1);
        @(negedge clk);

        // zero payload byte mid-packet, then a good packet
        b = '{8'h44, 8'h00, 8'h55, 8'h66};
        run_pkt(3'd2, 16'h00A7, b);
        b = '{8'hC1, 8'hC2};
        run_pkt(3'd7, 16'hFFFE, b);

        // overflow at 126 bytes; exactly 125 bytes fills to data_num 127
        run_pkt(3'd1, 16'h0005, rand_bytes(126));
        run_pkt(3'd6, 16'h0009, rand_bytes(125));

        // sop before eop: only the second packet is written
        b = '{8'hA1, 8'hA2};
        send_pkt(3'd4, 16'h0001, b, 1'b0);
        exp_err++;
        b = '{8'hB1, 8'hB2, 8'hB3};
        run_pkt(3'd3, 16'h000C, b);
        drain();
        chk("err_count_directed", 64'(err_seen), 64'(exp_err));

        // randomized traffic with random back-pressure and valid gaps
        gaps_en   = 1'b1;
        full_mode = 1;
        for (int p = 0; p < 150; p++) begin
            kind = $urandom_range(0, 9);
            pr   = 3'($urandom);
            ad   = 16'($urandom);
            if (kind == 0) begin
                beat(1'b0, 1'($urandom), 8'($urandom_range(1, 255)), pr, ad);
                exp_err++;
            end else if (kind == 1) begin
                b = rand_bytes($urandom_range(1, 8));
                b[$urandom_range(0, b.size() - 1)] = 8'h00;
                run_pkt(pr, ad, b);
            end else if (kind == 2) begin
                send_pkt(pr, ad, rand_bytes($urandom_range(1, 5)), 1'b0);
                exp_err++;
                run_pkt(3'($urandom), 16'($urandom), rand_bytes($urandom_range(1, 10)));
            end else if (kind == 3) begin
                run_pkt(pr, ad, rand_bytes($urandom_range(100, 127)));
            end else begin
                run_pkt(pr, ad, rand_bytes($urandom_range(1, 16)));
            end
        end
        gaps_en = 1'b0;
        drain();
        chk("err_count_total", 64'(err_seen), 64'(exp_err));
`ifdef DATA_IN_PACKER_STAT_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'(n_pushed));
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_err));
`endif

        // reset mid-packet loses the packet without a write
        b = '{8'h31, 8'h32, 8'h33};
        send_pkt(3'd2, 16'h0002, b, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_o_ready", 64'(bus.o_ready), 64'd0);
        chk_wide("midrst_queue_in", bus.Queue_in, '0);
        chk("midrst_data_num", 64'(bus.data_num), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_write", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
